// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_arbiter
//  Purpose  : Round-robin front end sharing one combinational AdderSubtractor
//             between NREQ requesters, with a registered, tagged response.
//  Revision : 1.0  initial release
// ============================================================================
module addsub_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_op,
  output logic [31:0]          au_a,
  output logic [31:0]          au_b,
  output logic                 au_ctl0,
  output logic                 au_ctl1,
  input  logic [31:0]          au_out,
  input  logic                 au_zero,
  input  logic                 au_overflow,
  input  logic                 au_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic                 rsp_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_found;
  logic           w_accept;
  logic [31:0]    w_sel_a;
  logic [31:0]    w_sel_b;
  logic [1:0]     w_sel_op;
  logic [31:0]    r_au_a;
  logic [31:0]    r_au_b;
  logic           r_ctl0;
  logic           r_ctl1;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_result;
  logic           r_zero;
  logic           r_overflow;
  logic           r_cout;

  // Two passes: indices at or above the pointer first, then the wrapped ones.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_grant = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (i < int'(r_ptr))) begin
        w_found = 1'b1;
        w_grant = IDW'(i);
      end
    end
  end

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_sel_a  = req_a[32*i +: 32];
        w_sel_b  = req_b[32*i +: 32];
        w_sel_op = req_op[2*i +: 2];
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_found;
  assign w_ptr_nxt = (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + IDW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant is gated by reset so req_ready drops in the same instant reset asserts.
  always_comb begin
    req_ready = '0;
    rsp_valid = (r_state == S_RESP);
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = reset_n && w_accept && (w_grant == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_au_a     <= '0;
      r_au_b     <= '0;
      r_ctl0     <= 1'b0;
      r_ctl1     <= 1'b0;
      r_id       <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_cout     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr  <= w_ptr_nxt;
        r_au_a <= w_sel_a;
        r_au_b <= w_sel_b;
        r_ctl1 <= w_sel_op[1];
        // op 2'b10 is folded onto SLT so ctl1=1/ctl0=0 never reaches the unit
        r_ctl0 <= w_sel_op[0] | w_sel_op[1];
        r_id   <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_result   <= au_out;
        r_zero     <= au_zero;
        r_overflow <= au_overflow;
        r_cout     <= au_cout;
      end
    end
  end

  assign au_a         = r_au_a;
  assign au_b         = r_au_b;
  assign au_ctl0      = r_ctl0;
  assign au_ctl1      = r_ctl1;
  assign rsp_id       = r_id;
  assign rsp_result   = r_result;
  assign rsp_zero     = r_zero;
  assign rsp_overflow = r_overflow;
  assign rsp_cout     = r_cout;

endmodule
`default_nettype wire
